pulse_event_arbiter: RTL and testbench

- Turns NUM_CH level inputs (buttons, status lines) into one-shot events and shares a single event output port between them.
- Each channel is edge-detected into a one-cycle pulse and latched as a pending request.
- A round-robin scheduler issues each pending request, one per handshake, on a valid/ready output carrying the channel index.
- Sits between the level-input device logic and the consumer that services device events.

---
 rtl/pulse_arb_pkg.sv | 37 +++
 rtl/pulse_event_arbiter_edge_pulse.sv | 22 ++
 rtl/pulse_event_arbiter.sv | 102 ++++++++++
 tb/tb_pulse_event_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for pulse_event_arbiter.
// Combinational helper only: it adds no latency and has no flow control.
package pulse_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;
    localparam int MAX_CH     = 32;

    // Returns the index of the first set bit of pend at or after ptr, wrapping at n.
    // It returns 0 when pend is empty, so callers only use the result when |pend.
    function automatic int unsigned rr_pick(
        input logic [MAX_CH-1:0] pend,
        input int unsigned       ptr,
        input int unsigned       n
    );
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (pend[idx[4:0]] && !found) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/pulse_event_arbiter_edge_pulse.sv
// Rising-edge detector for one level input: o_rise is high for the cycle the input goes 0->1.
// Latency is zero cycles from i_lvl to o_rise, and there is no backpressure.
module edge_pulse
    import pulse_arb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_lvl,
    output logic o_rise
);

    logic r_prev;

    // prev clears on reset, so an input already high at reset release yields one event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_prev <= 1'b0;
        else          r_prev <= i_lvl;
    end

    assign o_rise = i_lvl & ~r_prev;

endmodule

// File: rtl/pulse_event_arbiter.sv
// Converts NUM_CH level inputs into one-shot events and serves them round-robin on one valid/ready port.
// An edge on in_i shows up on v_o two cycles later. With ready_i low, id_o holds; repeat rises on a pending channel are counted as drops.
module pulse_event_arbiter
    import pulse_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int ID_W  = $clog2(NUM_CH)
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] in_i,
    input  logic              ready_i,
    input  logic              clear_drop_i,
    output logic              v_o,
    output logic [ID_W-1:0]   id_o,
    output logic [NUM_CH-1:0] pending_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    localparam logic [31:0]     CNT_MAX = (32'd1 << CNT_W) - 32'd1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CH - 1);

    state_t            r_state, w_state_nxt;
    logic [NUM_CH-1:0] r_pending, w_pending_nxt;
    logic [NUM_CH-1:0] w_rise, w_clr, w_drop;
    logic [ID_W-1:0]   r_ptr, w_ptr_nxt;
    logic [ID_W-1:0]   r_id, w_id_nxt;
    logic [ID_W-1:0]   w_pick_base, w_grant;
    logic              w_load;
    logic [CNT_W-1:0]  r_drop_cnt, w_drop_cnt_nxt;
    logic [31:0]       w_sum;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_edge
        edge_pulse u_edge (
            .clk     (clk),
            .reset_n (reset_n),
            .i_lvl   (in_i[k]),
            .o_rise  (w_rise[k])
        );
    end

    // On a handshake the next grant searches from the just-advanced pointer so there is no bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_pick_base = r_ptr;
        w_load      = 1'b0;
        w_id_nxt    = r_id;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    w_ptr_nxt   = (r_id == LAST_ID) ? '0 : r_id + ID_W'(1);
                    w_pick_base = w_ptr_nxt;
                    if (|r_pending) w_load = 1'b1;
                    else            w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_grant = ID_W'(rr_pick(MAX_CH'(r_pending), 32'(w_pick_base), NUM_CH));
        if (w_load) w_id_nxt = w_grant;
    end

    // A fresh rise beats the grant clear, so only rises onto a still-pending bit are drops.
    always_comb begin
        w_clr          = w_load ? (NUM_CH'(1) << w_grant) : '0;
        w_drop         = w_rise & r_pending & ~w_clr;
        w_pending_nxt  = (r_pending & ~w_clr) | w_rise;
        w_sum          = 32'(r_drop_cnt) + 32'($countones(w_drop));
        w_drop_cnt_nxt = (w_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(w_sum);
        if (clear_drop_i) w_drop_cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_ptr      <= '0;
            r_id       <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_ptr      <= w_ptr_nxt;
            r_id       <= w_id_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

    assign v_o        = (r_state == SEND);
    assign id_o       = r_id;
    assign pending_o  = r_pending;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Bench for pulse_event_arbiter: directed scenarios plus random traffic checked against an event-level model.
module tb_pulse_event_arbiter;

    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  in_i;
    logic          ready_i;
    logic          clear_drop_i;
    logic          v_o;
    logic [1:0]    id_o;
    logic [N-1:0]  pending_o;
    logic [CW-1:0] drop_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    int m_prev [N];
    int m_pend [N];
    int m_v, m_id, m_ptr, m_cnt;

    always #5 clk = ~clk;

    pulse_event_arbiter #(.NUM_CH(N), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_i         (in_i),
        .ready_i      (ready_i),
        .clear_drop_i (clear_drop_i),
        .v_o          (v_o),
        .id_o         (id_o),
        .pending_o    (pending_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int pend_vec();
        int r = 0;
        for (int k = 0; k < N; k++) if (m_pend[k] != 0) r = r | (1 << k);
        return r;
    endfunction

    function automatic int pick(input int ptr);
        for (int off = 0; off < N; off++) begin
            if (m_pend[(ptr + off) % N] != 0) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_prev[k] = 0;
            m_pend[k] = 0;
        end
        m_v = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Effect of one clock edge with the given inputs on the event-level state.
    task automatic model_step(input logic [N-1:0] in, input logic rdy, input logic clr);
        int rise [N];
        int g     = -1;
        int drops = 0;
        for (int k = 0; k < N; k++) rise[k] = (in[k] && m_prev[k] == 0) ? 1 : 0;
        if (m_v == 0) begin
            if (pend_vec() != 0) g = pick(m_ptr);
        end else if (rdy) begin
            m_ptr = (m_id + 1) % N;
            if (pend_vec() != 0) g = pick(m_ptr);
            else m_v = 0;
        end
        if (g >= 0) begin
            m_v  = 1;
            m_id = g;
        end
        for (int k = 0; k < N; k++) begin
            if (rise[k] != 0 && m_pend[k] != 0 && k != g) drops++;
            m_pend[k] = ((m_pend[k] != 0 && k != g) || rise[k] != 0) ? 1 : 0;
            m_prev[k] = in[k] ? 1 : 0;
        end
        if (clr) m_cnt = 0;
        else     m_cnt = (m_cnt + drops > CMAX) ? CMAX : m_cnt + drops;
    endtask

    task automatic compare_all();
        chk("v_o",        int'(v_o),        m_v);
        chk("id_o",       int'(id_o),       m_id);
        chk("pending_o",  int'(pending_o),  pend_vec());
        chk("drop_cnt_o", int'(drop_cnt_o), m_cnt);
    endtask

    task automatic drive(input logic [N-1:0] in, input logic rdy, input logic clr);
        in_i         = in;
        ready_i      = rdy;
        clear_drop_i = clr;
        model_step(in, rdy, clr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asserted and released between clock edges; outputs are checked while reset is held.
    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        compare_all();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [N-1:0] cur;
        reset_n      = 1'b0;
        in_i         = '0;
        ready_i      = 1'b0;
        clear_drop_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        chk("rst_v", int'(v_o), 0);
        chk("rst_pend", int'(pending_o), 0);
        chk("rst_cnt", int'(drop_cnt_o), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) drive(4'b0000, 1'b1, 1'b0);
        chk("idle_v", int'(v_o), 0);

        // Single held input: one event, then pointer lands on 3.
        drive(4'b0100, 1'b1, 1'b0);
        chk("ch2_pend", int'(pending_o), 4);
        chk("ch2_v_early", int'(v_o), 0);
        drive(4'b0100, 1'b1, 1'b0);
        chk("ch2_v", int'(v_o), 1);
        chk("ch2_id", int'(id_o), 2);
        for (int i = 0; i < 19; i++) begin
            drive(4'b0100, 1'b1, 1'b0);
            chk("ch2_held", int'(v_o), 0);
        end
        drive(4'b0000, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        chk("ptr3_id", int'(id_o), 3);
        drive(4'b1111, 1'b1, 1'b0);
        chk("ptr3_wrap", int'(id_o), 0);
        for (int i = 0; i < 4; i++) drive(4'b0000, 1'b1, 1'b0);

        // All four at once from a fresh pointer.
        do_reset();
        drive(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 1'b1, 1'b0);
            chk("burst_v", int'(v_o), 1);
            chk("burst_id", int'(id_o), i);
        end
        drive(4'b1111, 1'b1, 1'b0);
        chk("burst_end", int'(v_o), 0);

        // Backpressure on channel 1.
        do_reset();
        drive(4'b0010, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        chk("bp_id", int'(id_o), 1);
        chk("bp_pend", int'(pending_o), 2);
        chk("bp_cnt0", int'(drop_cnt_o), 0);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        chk("bp_cnt1", int'(drop_cnt_o), 1);
        drive(4'b0000, 1'b1, 1'b0);
        chk("bp_again_v", int'(v_o), 1);
        chk("bp_again_id", int'(id_o), 1);
        drive(4'b0000, 1'b1, 1'b0);
        chk("bp_done", int'(v_o), 0);

        // Drop counter saturation and clear priority.
        do_reset();
        drive(4'b0010, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0000, 1'b0, 1'b0);
            drive(4'b0010, 1'b0, 1'b0);
        end
        chk("sat_cnt", int'(drop_cnt_o), 3);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b1);
        chk("sat_clr", int'(drop_cnt_o), 0);

        // Reset while an event is presented.
        do_reset();
        drive(4'b1000, 1'b0, 1'b0);
        drive(4'b0101, 1'b0, 1'b0);
        chk("mid_v", int'(v_o), 1);
        chk("mid_id", int'(id_o), 3);
        chk("mid_pend", int'(pending_o), 5);
        do_reset();
        chk("mid_rst_v", int'(v_o), 0);
        drive(4'b0101, 1'b1, 1'b0);
        drive(4'b0101, 1'b1, 1'b0);
        chk("mid_id0", int'(id_o), 0);
        drive(4'b0101, 1'b1, 1'b0);
        chk("mid_id2", int'(id_o), 2);
        drive(4'b0101, 1'b1, 1'b0);
        chk("mid_idle", int'(v_o), 0);

        // Random traffic.
        cur = 4'b0101;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(0, 5) == 0) cur[k] = ~cur[k];
            if ($urandom_range(0, 999) == 0) do_reset();
            drive(cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
